dmem_access_ctrl: RTL
=====================

// Module: dmem_access_ctrl
// PURPOSE
//  Load/store controller between the processor MEM stage and the syncram data memory.
//  Accepts one byte/half/word load or store per handshake and word-aligns the address.
//  Loads: extracts and zero/sign-extends the addressed lane. Sub-word stores: read-modify-write.
//  Byte order is big-endian (DLX): byte offset 0 occupies bits [31:24].
// PARAMETERS
//  (none overridable; data and address widths are fixed at 32 to match syncram)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   reset, asynchronous, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   controller idle, request accepted on valid&ready edge
//  req_op       in   3   op code, `DM_* encodings
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid   out  1   one-cycle pulse, access complete
//  resp_rdata   out  32  extended load result (0 for stores and errors)
//  resp_err     out  1   misaligned access, valid with resp_valid
//  mem_cs       out  1   syncram chip select
//  mem_oe       out  1   syncram read enable
//  mem_we       out  1   syncram write enable
//  mem_addr     out  32  word address to syncram, {req_addr[31:2],2'b00}
//  mem_din      out  32  write data to syncram
//  mem_dout     in   32  syncram read data, valid the cycle after a cs&oe edge
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, req_ready=1; resp_valid, resp_err, mem_cs,
//    mem_oe, mem_we = 0; resp_rdata, mem_addr, mem_din = 0.
//  - FSM: IDLE, RD, CAP, WR, RESP. req_ready=1 only in IDLE.
//  - IDLE, accept: latch op/addr/wdata.
//    Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) -> RESP with err=1,
//    no memory strobe. SW -> WR. Otherwise -> RD.
//  - RD: mem_cs=1, mem_oe=1, mem_we=0 for exactly one cycle -> CAP.
//  - CAP: strobes low; sample mem_dout.
//    Load -> resp_rdata=extracted lane (LB/LH sign-extend, LBU/LHU zero-extend, LW raw) -> RESP.
//    SB/SH -> merge wdata lane into the sampled word, register the result as mem_din -> WR.
//  - WR: mem_cs=1, mem_we=1, mem_oe=0 for exactly one cycle -> RESP.
//  - RESP: resp_valid=1 for one cycle -> IDLE. resp_rdata/resp_err hold until the next RESP.
//  - Latency, accept edge to resp_valid cycle: err 1; SW 2; loads 3; SB/SH 4.
//  - Lanes: byte k (k=addr[1:0]) = word[31-8k -: 8]; half h (h=addr[1]) = word[31-16h -: 16].
//  - req_valid while busy: ignored; the requester holds it until req_ready.
//  - Back-to-back: a new request may be accepted in the IDLE cycle after RESP.
//  - No cycle has mem_oe and mem_we both high.
//  - rst asserted mid-operation: immediate return to IDLE, strobes drop asynchronously,
//    pending write discarded, no resp_valid.
// STRUCTURE
//  - Shared include dmem_defs.vh:
//    op codes DM_LB=0, DM_LH=1, DM_LW=2, DM_LBU=3, DM_LHU=4, DM_SB=5, DM_SH=6, DM_SW=7;
//    state encodings.
//  - One combinational sub-module, dmem_lane_align:
//    (word, off, op) -> extracted/extended load value and merged store word.
//  - The FSM and registers stay in this module.
// TESTING
//  (syncram preloaded with 0x00000100 / 0x8899AABB)
//  1. LB 0x101 -> resp_rdata=0xFFFFFF99, err=0, resp_valid 3 cycles after accept,
//     one RD strobe, mem_addr=0x100.
//  2. LBU 0x103 -> 0x000000BB; LHU 0x102 -> 0x0000AABB; LH 0x100 -> 0xFFFF8899; LW 0x100 -> 0x8899AABB.
//  3. SB 0x102, wdata 0x12345655 -> one read, then a write with mem_din=0x889955BB;
//     LW 0x100 -> 0x889955BB.
//  4. SW 0x104, wdata 0xDEADBEEF -> only a write strobe, latency 2;
//     LH 0x106 -> 0xFFFFBEEF.
//  5. SH 0x101 and LW 0x102 -> resp_err=1 one cycle after accept, mem_cs never high, memory unchanged.
//  6. Assert rst during the WR state of an SB -> outputs reset at once, no resp_valid,
//     word unchanged; then req_ready=1 and the next LW completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: op codes, FSM states
// and small decode helpers used by the controller and its lane aligner.
package dmem_access_ctrl_pkg;

  localparam int unsigned DM_DATA_W = 32;
  localparam int unsigned DM_ADDR_W = 32;

  localparam logic [2:0] DM_LB  = 3'd0;
  localparam logic [2:0] DM_LH  = 3'd1;
  localparam logic [2:0] DM_LW  = 3'd2;
  localparam logic [2:0] DM_LBU = 3'd3;
  localparam logic [2:0] DM_LHU = 3'd4;
  localparam logic [2:0] DM_SB  = 3'd5;
  localparam logic [2:0] DM_SH  = 3'd6;
  localparam logic [2:0] DM_SW  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } dm_state_e;

  function automatic logic dm_is_load(input logic [2:0] op);
    return (op == DM_LB) || (op == DM_LH) || (op == DM_LW) ||
           (op == DM_LBU) || (op == DM_LHU);
  endfunction

  function automatic logic dm_is_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic w_bad;
    w_bad = 1'b0;
    case (op)
      DM_LH, DM_LHU, DM_SH: w_bad = off[0];
      DM_LW, DM_SW:         w_bad = (off != 2'b00);
      default:              w_bad = 1'b0;
    endcase
    return w_bad;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane_align.sv
// Big-endian lane handling: byte offset 0 is bits [31:24]. Extracts/extends load
// lanes and merges sub-word store data into a previously read word.
module dmem_access_ctrl_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_op,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0:    w_byte = i_word[31:24];
      2'd1:    w_byte = i_word[23:16];
      2'd2:    w_byte = i_word[15:8];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_off[1] ? i_word[15:0] : i_word[31:16];
  end

  always_comb begin
    o_load_data = 32'h0000_0000;
    case (i_op)
      DM_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      DM_LBU:  o_load_data = {24'h00_0000, w_byte};
      DM_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      DM_LHU:  o_load_data = {16'h0000, w_half};
      DM_LW:   o_load_data = i_word;
      default: o_load_data = 32'h0000_0000;
    endcase
  end

  // Only the addressed lane changes; the rest of the word is written back as read.
  always_comb begin
    o_store_word = i_word;
    if (i_op == DM_SB) begin
      case (i_off)
        2'd0:    o_store_word[31:24] = i_wdata[7:0];
        2'd1:    o_store_word[23:16] = i_wdata[7:0];
        2'd2:    o_store_word[15:8]  = i_wdata[7:0];
        default: o_store_word[7:0]   = i_wdata[7:0];
      endcase
    end else if (i_op == DM_SH) begin
      if (i_off[1]) o_store_word[15:0]  = i_wdata;
      else          o_store_word[31:16] = i_wdata;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store controller between the MEM stage and the syncram data memory.
// Word-aligns addresses, extends loads, and performs read-modify-write for SB/SH.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_mem_cs,
  output logic        o_mem_oe,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_din,
  input  logic [31:0] i_mem_dout
);

  dm_state_e   r_state;
  dm_state_e   w_state_nxt;

  logic [2:0]  r_op;
  logic [1:0]  r_off;
  logic [15:0] r_wdata;
  logic        r_ready;
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_cs;
  logic        r_oe;
  logic        r_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_din;

  logic        w_accept;
  logic        w_misaligned;
  logic [31:0] w_load_data;
  logic [31:0] w_store_word;
  logic [31:0] w_rdata_nxt;
  logic        w_err_nxt;

  assign w_accept     = i_req_valid && (r_state == ST_IDLE);
  assign w_misaligned = dm_is_misaligned(i_req_op, i_req_addr[1:0]);

  dmem_access_ctrl_lane_align u_lane_align (
    .i_word       (i_mem_dout),
    .i_off        (r_off),
    .i_op         (r_op),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_misaligned) begin
            w_state_nxt = ST_RESP;
            w_rdata_nxt = 32'h0000_0000;
            w_err_nxt   = 1'b1;
          end else if (i_req_op == DM_SW) begin
            w_state_nxt = ST_WR;
          end else begin
            w_state_nxt = ST_RD;
          end
        end
      end
      ST_RD:  w_state_nxt = ST_CAP;
      ST_CAP: begin
        if (dm_is_load(r_op)) begin
          w_state_nxt = ST_RESP;
          w_rdata_nxt = w_load_data;
          w_err_nxt   = 1'b0;
        end else begin
          w_state_nxt = ST_WR;
        end
      end
      ST_WR: begin
        w_state_nxt = ST_RESP;
        w_rdata_nxt = 32'h0000_0000;
        w_err_nxt   = 1'b0;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe is high for exactly
  // the cycle spent in RD or WR, and drops asynchronously on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'h0000_0000;
      r_err        <= 1'b0;
      r_cs         <= 1'b0;
      r_oe         <= 1'b0;
      r_we         <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_mem_din    <= 32'h0000_0000;
      r_op         <= DM_LB;
      r_off        <= 2'b00;
      r_wdata      <= 16'h0000;
    end else begin
      r_ready      <= (w_state_nxt == ST_IDLE);
      r_resp_valid <= (w_state_nxt == ST_RESP);
      r_cs         <= (w_state_nxt == ST_RD) || (w_state_nxt == ST_WR);
      r_oe         <= (w_state_nxt == ST_RD);
      r_we         <= (w_state_nxt == ST_WR);
      r_rdata      <= w_rdata_nxt;
      r_err        <= w_err_nxt;
      if (w_accept) begin
        r_op       <= i_req_op;
        r_off      <= i_req_addr[1:0];
        r_wdata    <= i_req_wdata[15:0];
        r_mem_addr <= {i_req_addr[31:2], 2'b00};
        if ((i_req_op == DM_SW) && !w_misaligned) r_mem_din <= i_req_wdata;
      end
      if ((r_state == ST_CAP) && !dm_is_load(r_op)) r_mem_din <= w_store_word;
    end
  end

  assign o_req_ready  = r_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;
  assign o_mem_cs     = r_cs;
  assign o_mem_oe     = r_oe;
  assign o_mem_we     = r_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_din    = r_mem_din;

endmodule
